// File: rtl/synth_pkg.sv
// Shared constants, wave-mode / FSM encodings and table builders for the
// polyphonic sample generator. The two table functions are evaluated once
// per ROM entry at elaboration; they are never called with run-time values.
package synth_pkg;

    localparam int DEFAULT_N      = 24;
    localparam int DEFAULT_M      = 12;
    localparam int SINE_ADDR_W    = 10;
    localparam int SINE_ENTRIES   = 1 << SINE_ADDR_W;
    localparam int MIDI_NOTES     = 128;
    localparam int SAMPLE_RATE_HZ = 48000;
    localparam int NOTE0_FREQ_MHZ = 8176;   // MIDI note 0 (C-1) in millihertz

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2
    } state_t;

    // Equal-tempered semitone ratios 2^(s/12) in Q16.
    function automatic int semitone_q16(input int s);
        case (s)
            0:       return 65536;
            1:       return 69433;
            2:       return 73562;
            3:       return 77936;
            4:       return 82570;
            5:       return 87480;
            6:       return 92682;
            7:       return 98193;
            8:       return 104032;
            9:       return 110218;
            10:      return 116772;
            11:      return 123715;
            default: return 65536;
        endcase
    endfunction

    // Phase increment per sample for a MIDI note: f * 2^n / Fs.
    function automatic longint freq_step(input int note, input int n);
        longint num;
        num = longint'(NOTE0_FREQ_MHZ) * longint'(semitone_q16(note % 12));
        num = num << (note / 12);
        if (n >= 16)
            num = num << (n - 16);
        else
            num = num >> (16 - n);
        return num / (longint'(SAMPLE_RATE_HZ) * 1000);
    endfunction

    // Sine entry via the Bhaskara rational approximation over each half
    // period; exact zero at entries 0/512 and exact +amp at entry 256.
    function automatic int sine_entry(input int i, input int amp);
        longint half, t, u, den, mag;
        half = longint'(SINE_ENTRIES / 2);
        t    = longint'(i) % half;
        u    = t * (half - t);
        den  = (5 * half * half) / 4 - u;
        mag  = (longint'(amp) * 4 * u + den / 2) / den;
        return (i < SINE_ENTRIES / 2) ? int'(mag) : -int'(mag);
    endfunction

endpackage

// File: rtl/poly_voice_wave.sv
// Waveform lookup for the voice currently being accumulated: frequency-step
// ROM (MIDI note -> phase increment) and sine / square waveform selection.
// Sawtooth and triangle exist only with POLY_SAMPLE_GEN_SAW_TRI_EN defined;
// otherwise modes 2 and 3 fall through to sine.
module poly_voice_wave
    import synth_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int M  = DEFAULT_M,
    parameter int PW = SINE_ADDR_W
) (
    input  logic [PW-1:0]       phase_top,
    input  logic [6:0]          note,
    input  logic [1:0]          mode,
    output logic signed [M-1:0] wave,
    output logic [N-1:0]        step
);

    localparam int AMP = (1 << (M - 1)) - 1;
    localparam logic signed [M-1:0] SQ_HIGH = {1'b0, {(M-1){1'b1}}};
    localparam logic signed [M-1:0] SQ_LOW  = {1'b1, {(M-1){1'b0}}};

    logic signed [M-1:0]    sine_rom [SINE_ENTRIES];
    logic [N-1:0]           step_rom [MIDI_NOTES];
    logic [SINE_ADDR_W-1:0] sine_idx;

    for (genvar g = 0; g < SINE_ENTRIES; g++) begin : g_sine
        assign sine_rom[g] = M'(sine_entry(g, AMP));
    end

    for (genvar g = 0; g < MIDI_NOTES; g++) begin : g_step
        assign step_rom[g] = N'(freq_step(g, N));
    end

    assign step     = step_rom[note];
    assign sine_idx = phase_top[PW-1 -: SINE_ADDR_W];

`ifdef POLY_SAMPLE_GEN_SAW_TRI_EN
    logic [M-1:0] fold;

    // Triangle folds the lower phase bits on the second half period.
    always_comb begin
        fold = phase_top[PW-2 -: M];
        if (phase_top[PW-1])
            fold = ~phase_top[PW-2 -: M];
    end
`endif

    // Select the waveform value for the active mode; sine is the fallback.
    always_comb begin
        wave = sine_rom[sine_idx];
        case (wave_mode_t'(mode))
            WAVE_SQUARE: wave = phase_top[PW-1] ? SQ_LOW : SQ_HIGH;
`ifdef POLY_SAMPLE_GEN_SAW_TRI_EN
            WAVE_SAW:    wave = {~phase_top[PW-1], phase_top[PW-2 -: M-1]};
            WAVE_TRI:    wave = {~fold[M-1], fold[M-2:0]};
`endif
            default:     wave = sine_rom[sine_idx];
        endcase
    end

endmodule

// File: rtl/poly_sample_generator.sv
// Polyphonic sample generator: on each accepted sample-clock rising edge,
// walks all voices one per cycle, sums the gated voices' waveform values and
// emits the average. Optional saw/triangle modes: POLY_SAMPLE_GEN_SAW_TRI_EN.
module poly_sample_generator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int N          = DEFAULT_N,
    parameter int M          = DEFAULT_M
) (
    input  logic                          inCLK_50MHZ,
    input  logic                          inRST_N,
    input  logic                          inSAMPLE_CLK,
    input  logic [1:0]                    inWaveMode,
    input  logic                          inVoiceWrite,
    input  logic [$clog2(NUM_VOICES)-1:0] inVoiceIdx,
    input  logic                          inVoiceGate,
    input  logic [6:0]                    inMidiFrequencyIndex,
    output logic signed [M-1:0]           outSample,
    output logic                          outSampleReady,
    output logic                          outBusy
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int AW = M + VW;   // sum of NUM_VOICES full-scale values fits
`ifdef POLY_SAMPLE_GEN_SAW_TRI_EN
    localparam int PW = M + 1;    // saw needs M bits, triangle one more
`else
    localparam int PW = SINE_ADDR_W;
`endif

    state_t               state, state_next;
    logic                 sclk_q;
    logic                 sclk_rise;
    logic                 frame_start;
    logic [VW-1:0]        vidx;
    logic [1:0]           mode_q;
    logic signed [AW-1:0] acc;

    logic                 gate  [NUM_VOICES];
    logic [6:0]           note  [NUM_VOICES];
    logic [N-1:0]         phase [NUM_VOICES];

    logic                 cur_gate;
    logic                 advance;
    logic [PW-1:0]        phase_top;
    logic signed [M-1:0]  wave_val;
    logic [N-1:0]         step;

    assign sclk_rise = inSAMPLE_CLK & ~sclk_q;
    assign cur_gate  = gate[vidx];
    assign advance   = (state == ST_ACCUM) && cur_gate;
    assign phase_top = phase[vidx][N-1 -: PW];
    assign outBusy   = (state != ST_IDLE);

    poly_voice_wave #(
        .N  (N),
        .M  (M),
        .PW (PW)
    ) u_wave (
        .phase_top (phase_top),
        .note      (note[vidx]),
        .mode      (mode_q),
        .wave      (wave_val),
        .step      (step)
    );

    // Registered copy of the sample clock for rising-edge detection.
    always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
        if (!inRST_N)
            sclk_q <= 1'b0;
        else
            sclk_q <= inSAMPLE_CLK;
    end

    // FSM state register.
    always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
        if (!inRST_N)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next state; edges seen while busy are dropped, not queued.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sclk_rise) begin
                    state_next  = ST_ACCUM;
                    frame_start = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (vidx == VW'(NUM_VOICES - 1))
                    state_next = ST_SCALE;
            end
            ST_SCALE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Frame datapath: clear/latch mode at start, accumulate, then scale out.
    always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
        if (!inRST_N) begin
            acc            <= '0;
            mode_q         <= '0;
            vidx           <= '0;
            outSample      <= '0;
            outSampleReady <= 1'b0;
        end else begin
            outSampleReady <= 1'b0;
            if (frame_start) begin
                acc    <= '0;
                mode_q <= inWaveMode;
                vidx   <= '0;
            end else if (state == ST_ACCUM) begin
                if (cur_gate)
                    acc <= acc + {{VW{wave_val[M-1]}}, wave_val};
                vidx <= vidx + 1'b1;
            end else if (state == ST_SCALE) begin
                outSample      <= M'(acc >>> VW);
                outSampleReady <= 1'b1;
            end
        end
    end

    // Voice registers: writes land on the next edge; the voice being
    // processed uses its pre-write values, and only a gate 0->1 retriggers.
    always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
        if (!inRST_N) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                gate[v]  <= 1'b0;
                note[v]  <= '0;
                phase[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (inVoiceWrite && (inVoiceIdx == VW'(v))) begin
                    gate[v] <= inVoiceGate;
                    note[v] <= inMidiFrequencyIndex;
                end
                if (inVoiceWrite && (inVoiceIdx == VW'(v)) && inVoiceGate && !gate[v])
                    phase[v] <= '0;
                else if (advance && (vidx == VW'(v)))
                    phase[v] <= phase[v] + step;
            end
        end
    end

endmodule

// File: tb/tb_poly_sample_generator.sv
// Directed bench for poly_sample_generator (NUM_VOICES=4, N=24, M=12).
// Expected values are hand-computed; note 127 steps the phase by 4384500
// per frame, note 0 by 2857.
module tb_poly_sample_generator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sclk;
    logic [1:0]        mode;
    logic              vwrite;
    logic [1:0]        vidx;
    logic              vgate;
    logic [6:0]        vnote;
    logic signed [11:0] sample;
    logic              ready;
    logic              busy;

    int total = 0;
    int bad   = 0;

`ifdef POLY_SAMPLE_GEN_SAW_TRI_EN
    localparam int EXP_M2_F0 = -512;
    localparam int EXP_M2_F1 = -245;
    localparam int EXP_M3_F0 = -512;
`else
    localparam int EXP_M2_F0 = 0;
    localparam int EXP_M2_F1 = 510;
    localparam int EXP_M3_F0 = 0;
`endif

    always #10 clk = ~clk;

    poly_sample_generator #(
        .NUM_VOICES (4),
        .N          (24),
        .M          (12)
    ) dut (
        .inCLK_50MHZ          (clk),
        .inRST_N              (rst_n),
        .inSAMPLE_CLK         (sclk),
        .inWaveMode           (mode),
        .inVoiceWrite         (vwrite),
        .inVoiceIdx           (vidx),
        .inVoiceGate          (vgate),
        .inMidiFrequencyIndex (vnote),
        .outSample            (sample),
        .outSampleReady       (ready),
        .outBusy              (busy)
    );

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Called at posedge+1; leaves the bench at posedge+1.
    task automatic write_voice(input int v, input bit g, input int n);
        vwrite = 1'b1;
        vidx   = 2'(v);
        vgate  = g;
        vnote  = 7'(n);
        @(posedge clk); #1;
        vwrite = 1'b0;
    endtask

    // One sample-clock pulse; checks latency, pulse count, busy and value.
    task automatic frame(input string tag, input int exp_val);
        int seen_at = 0;
        int pulses  = 0;
        int val     = 99999;
        int busy_k5 = 0;
        int busy_k6 = 1;
        sclk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 2) sclk = 1'b0;
            if (k == 5) busy_k5 = int'(busy);
            if (k == 6) busy_k6 = int'(busy);
            if (ready) begin
                pulses++;
                if (seen_at == 0) begin
                    seen_at = k;
                    val     = int'(sample);
                end
            end
        end
        check({tag, "_lat"}, seen_at, 6);
        check({tag, "_cnt"}, pulses, 1);
        check({tag, "_busy"}, busy_k5, 1);
        check({tag, "_idle"}, busy_k6, 0);
        check({tag, "_val"}, val, exp_val);
    endtask

    initial begin
        int pulses;
        int val;
        rst_n  = 1'b0;
        sclk   = 1'b0;
        mode   = 2'd1;
        vwrite = 1'b0;
        vidx   = '0;
        vgate  = 1'b0;
        vnote  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", int'(sample), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // No voices gated: silence, phases untouched.
        for (int f = 0; f < 10; f++) frame("silent", 0);
        for (int i = 0; i < 4; i++) check("silent_phase", int'(dut.phase[i]), 0);

        // Single square voice at phase 0: 2047 >>> 2.
        mode = 2'd1;
        write_voice(0, 1'b1, 0);
        frame("sq1v", 511);

        // Four square voices on note 127; third frame crosses half period.
        write_voice(0, 1'b0, 0);
        for (int v = 0; v < 4; v++) write_voice(v, 1'b1, 127);
        frame("sq4v_f0", 2047);
        frame("sq4v_f1", 2047);
        frame("sq4v_f2", -2048);
        // Gate 1->1 write must not retrigger voice 0.
        write_voice(0, 1'b1, 127);
        frame("noretrig", -2048);

        // Second edge while busy is dropped.
        for (int v = 0; v < 4; v++) write_voice(v, 1'b0, 0);
        write_voice(0, 1'b1, 0);
        pulses = 0;
        val    = 99999;
        sclk   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 2) sclk = 1'b0;
            if (k == 3) sclk = 1'b1;
            if (k == 4) sclk = 1'b0;
            if (ready) begin
                pulses++;
                val = int'(sample);
            end
        end
        check("busy_edge_cnt", pulses, 1);
        check("busy_edge_val", val, 511);
        frame("post_busy", 511);

        // Reset in the middle of ACCUM.
        sclk = 1'b1;
        @(posedge clk); #1;
        sclk = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_sample", int'(sample), 0);
        check("arst_ready", int'(ready), 0);
        check("arst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("arst_no_ready", pulses, 0);
        write_voice(0, 1'b1, 0);
        frame("post_rst", 511);

        // Sine on note 127: phase 0 -> 0, phase 4384500 -> entry 267 = 2042.
        mode = 2'd0;
        write_voice(0, 1'b0, 0);
        write_voice(0, 1'b1, 127);
        frame("sine_f0", 0);
        frame("sine_f1", 510);

        // Mode 2: sawtooth when enabled, otherwise identical to sine.
        mode = 2'd2;
        write_voice(0, 1'b0, 0);
        write_voice(0, 1'b1, 127);
        frame("m2_f0", EXP_M2_F0);
        frame("m2_f1", EXP_M2_F1);

        // Mode 3: triangle bottom at phase 0 when enabled, else sine.
        mode = 2'd3;
        write_voice(0, 1'b0, 0);
        write_voice(0, 1'b1, 127);
        frame("m3_f0", EXP_M3_F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poly_sample_generator.md
POLY_SAMPLE_GENERATOR -- requirements
Module: poly_sample_generator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of independent voices (power of two, 2..16).
REQ-002 SHALL have parameter N, default 24, per-voice phase accumulator width.
REQ-003 SHALL have parameter M, default 12, signed output sample width.
REQ-004 SHALL have port inCLK_50MHZ  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port inRST_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port inSAMPLE_CLK  input  1  sample-rate level signal, synchronous to inCLK_50MHZ.
REQ-007 SHALL have port inWaveMode  input  2  global waveform select.
REQ-008 SHALL have port inVoiceWrite  input  1  single-cycle voice register write strobe.
REQ-009 SHALL have port inVoiceIdx  input  log2(NUM_VOICES)  voice addressed by the write.
REQ-010 SHALL have port inVoiceGate  input  1  written gate: 1 note on, 0 note off.
REQ-011 SHALL have port inMidiFrequencyIndex  input  7  written MIDI note index.
REQ-012 SHALL have port outSample  output  M  signed mixed sample.
REQ-013 SHALL have port outSampleReady  output  1  one-cycle pulse when outSample updates.
REQ-014 SHALL have port outBusy  output  1  high while a frame is being computed.

Function
REQ-015 SHALL start a frame only on a 0->1 transition of inSAMPLE_CLK, detected against a registered copy.
REQ-016 SHALL use FSM IDLE -> ACCUM (one voice per cycle, index 0..NUM_VOICES-1) -> SCALE -> IDLE; outBusy high in ACCUM and SCALE.
REQ-017 SHALL, in ACCUM for a gated voice, add that voice's waveform value at its current phase to the accumulator, then advance phase by the frequency step for its stored index (mod 2^N).
REQ-018 SHALL have ungated voices contribute 0 and leave their phase unchanged.
REQ-019 SHALL size the accumulator at M+log2(NUM_VOICES) bits signed, never overflow, and clear it on frame start.
REQ-020 SHALL, in SCALE, load outSample with the accumulator arithmetically shifted right by log2(NUM_VOICES) and pulse outSampleReady for exactly one cycle.
REQ-021 SHALL pulse outSampleReady exactly NUM_VOICES+2 cycles after the cycle in which the rising edge is sampled.
REQ-022 SHALL ignore a sample-clock rising edge arriving while outBusy is high; no queuing.
REQ-023 SHALL accept voice writes in any cycle; a write updates the gate and index registers on the next edge.
REQ-024 SHALL use the pre-write register values for a voice written in the same cycle that voice is processed.
REQ-025 SHALL clear a voice's phase to 0 on a gate 0->1 write; a gate 1->1 write changes the index only, without retrigger.
REQ-026 SHALL index waveforms using phase[N-1:N-10] for sine (1024 entries, entry 256 = +2^(M-1)-1) and phase[N-1] for square (0 -> +2^(M-1)-1, 1 -> -2^(M-1)).
REQ-027 SHALL sample inWaveMode once per frame at frame start.

Reset
REQ-028 SHALL on inRST_N low immediately force: FSM IDLE, outSample 0, outSampleReady 0, outBusy 0, all phases 0, all gates 0, all indices 0, accumulator 0, edge register 0.
REQ-029 SHALL abandon an in-progress frame on reset without emitting outSampleReady; the first frame after release requires a fresh inSAMPLE_CLK rising edge.

Configuration
REQ-030 SHALL, with macro POLY_SAMPLE_GEN_SAW_TRI_EN defined, support mode 2 sawtooth (phase[N-1:N-M] with MSB inverted, signed) and mode 3 triangle (folded phase, -2^(M-1) at phase 0, peak +2^(M-1)-1 at half period).
REQ-031 SHALL, without the macro, treat modes 2 and 3 as sine and contain no saw/triangle logic.

Structure
REQ-032 SHALL place N/M defaults, wave-mode codes (SINE=0, SQUARE=1, SAW=2, TRI=3) and FSM state encoding in shared package synth_pkg.
REQ-033 SHALL implement waveform selection and table lookup in one sub-module, poly_voice_wave, reusing the team's existing frequency-step and sinewave tables.

Verification
REQ-034 SHALL verify: NUM_VOICES=4, voice 0 gated, square mode, phase 0, one edge -> outSample=511 after 6 cycles, single ready pulse.
REQ-035 SHALL verify: all 4 voices gated, square mode, phases 0 -> outSample=2047; after phases pass half period -> -2048.
REQ-036 SHALL verify: no voices gated, 10 edges -> outSample=0 on each ready pulse, phases stay 0.
REQ-037 SHALL verify: second edge during outBusy -> ignored, exactly one ready pulse per accepted frame.
REQ-038 SHALL verify: inRST_N asserted mid-ACCUM -> all outputs 0 at once, no ready pulse, next edge yields normal frame.
REQ-039 SHALL verify: macro defined, mode 2, one voice at phase 0 -> contribution -2048; macro undefined, mode 2 -> output equals sine result.
